nios2_jtag_debug_sysclk_bridge: RTL and testbench
=================================================

Name: nios2_jtag_debug_sysclk_bridge

Overview:
- System-clock-side half of the Nios II JTAG debug link, generalised for wider IR/DR and multiple outstanding commands.
- Synchronises virtual-JTAG update strobes (vs_udr, vs_uir) from the tck domain and captures the shift register and IR into a command FIFO.
- Issues commands to the OCI debug logic through a valid/ready handshake, then pulses one-hot take_action / take_no_action per IR code.
- Replaces the fixed 2-bit-IR, 38-bit, unbuffered sysclk block.

Parameters:
- IR_W, 2: IR width; number of action channels is NUM_CH = 2**IR_W.
- DR_W, 38: shift-register / jdo width.
- ACTION_BIT, 37: jdo bit that selects take_action (1) or take_no_action (0); must be less than DR_W.
- DEPTH, 4: command FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2: synchroniser flops on vs_udr and vs_uir; at least 2.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- ir_in  in  IR_W  virtual-JTAG IR, tck domain, quasi-static.
- sr  in  DR_W  tck-domain shift register, quasi-static.
- vs_udr  in  1  update-DR strobe, asynchronous level.
- vs_uir  in  1  update-IR strobe, asynchronous level.
- cmd_ready  in  1  OCI logic can accept a command this cycle.
- clr_overflow  in  1  clears the overflow flag.
- cmd_valid  out  1  FIFO not empty.
- jdo  out  DR_W  DR of the last accepted command.
- jdo_ir  out  IR_W  IR of the last accepted command.
- take_action  out  NUM_CH  one-cycle one-hot pulse.
- take_no_action  out  NUM_CH  one-cycle one-hot pulse.
- ir_update  out  1  one-cycle pulse per synchronised vs_uir rise.
- fifo_level  out  $clog2(DEPTH)+1  number of occupied entries.
- overflow  out  1  sticky: a command was dropped.

Behaviour:
- Reset values: all outputs 0; FIFO empty; synchroniser flops 0; edge-arm flags 0.
- Synchroniser and edge detect:
  - Each strobe passes through SYNC_STAGES flops, then a rising-edge detector.
  - Arm flag: an edge is accepted only after the synchronised strobe has been seen low at least once since reset. A strobe held high across reset release produces no command.
- Capture:
  - A udr edge writes {ir_in, sr} into the FIFO on the next clk edge.
  - If vs_udr is first sampled high at edge N, the write occurs at edge N+SYNC_STAGES and cmd_valid is high after that edge.
  - The tck side holds sr and ir_in stable for at least SYNC_STAGES+2 clk periods after raising vs_udr.
- Issue:
  - The head entry is accepted on a clk edge where cmd_valid and cmd_ready are both 1.
  - On that edge, jdo and jdo_ir load the head entry and the FIFO pops.
  - In the following cycle exactly one bit pulses for one cycle: take_action[jdo_ir] if jdo[ACTION_BIT]=1, otherwise take_no_action[jdo_ir].
  - jdo and jdo_ir hold until the next acceptance.
  - Back-to-back acceptances give back-to-back pulses.
  - cmd_ready may be asserted while cmd_valid=0; it has no effect.
- Full FIFO:
  - Write while full with no pop in the same cycle: the new command is dropped, FIFO contents are unchanged, overflow is set.
  - Write and pop in the same cycle while full: the pop frees an entry and the write succeeds; level stays DEPTH.
  - Write and pop in the same cycle while empty: not possible, because a write is only visible in the cycle after it.
- overflow:
  - Cleared by clr_overflow.
  - If a drop and clr_overflow occur in the same cycle, set wins.
- ir_update: same latency as the FIFO write (pulse after edge N+SYNC_STAGES). It does not touch the FIFO or jdo.
- Pointers: FIFO pointers wrap modulo DEPTH; fifo_level is registered and ranges 0..DEPTH.
- Reset mid-operation: asynchronously clears the FIFO, pointers, jdo, overflow and any pending pulse. The edge-arm flags must re-arm before further edges are accepted.

Optional Feature:
- Macro: NIOS2_JTAG_BRIDGE_CMD_COUNT_EN.
- With the macro defined:
  - Adds outputs cmd_count[15:0] (incremented per accepted command) and drop_count[15:0] (incremented per dropped command).
  - Both counters wrap at 16'hFFFF → 0, reset to 0, and are cleared by clr_overflow.
  - If an increment and clr_overflow occur in the same cycle, the counter loads 1.
- Without the macro: the ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Single command: defaults, cmd_ready=1, ir_in=2'b01, sr=38'h20_0000_1234, pulse vs_udr → cmd_valid high for one cycle; jdo=38'h20_0000_1234, jdo_ir=1; take_action=4'b0010 for one cycle, 3 clk edges after first sampling; take_no_action stays 0.
- No-action decode: sr bit37=0, ir_in=3 → take_no_action=4'b1000 one-cycle pulse; take_action=0.
- Backpressure and overflow: cmd_ready=0, 5 udr pulses with distinct sr → fifo_level=4, overflow=1 (drop_count=1 with the feature). Raise cmd_ready → 4 consecutive pulses in write order; the 5th command is never issued. clr_overflow → overflow=0.
- Full with simultaneous pop: FIFO full, udr edge write in the same cycle as an acceptance → level stays 4, overflow stays 0, new entry issued last.
- Reset release with vs_udr held high → no cmd_valid. Lower then raise vs_udr → exactly one command.
- ir_update: pulse vs_uir → ir_update one-cycle pulse; fifo_level unchanged. Assert reset_n low mid-burst with 2 entries → cmd_valid=0, fifo_level=0, jdo=0 immediately.

Source files
------------

// File: rtl/nios2_jtag_debug_sysclk_bridge_if.sv
// Command bus between the sysclk JTAG debug bridge and the OCI debug logic.
// The bridge is the master: it offers commands (cmd_valid, jdo, jdo_ir)
// and pulses the decoded action strobes; the OCI side answers with cmd_ready.
`timescale 1ns/1ps

interface nios2_jtag_debug_sysclk_bridge_if #(
    parameter int IR_W = 2,
    parameter int DR_W = 38
);
    localparam int NUM_CH = 2 ** IR_W;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [DR_W-1:0]   jdo;
    logic [IR_W-1:0]   jdo_ir;
    logic [NUM_CH-1:0] take_action;
    logic [NUM_CH-1:0] take_no_action;

    modport master (
        output cmd_valid,
        output jdo,
        output jdo_ir,
        output take_action,
        output take_no_action,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  jdo,
        input  jdo_ir,
        input  take_action,
        input  take_no_action,
        output cmd_ready
    );
endinterface

// File: rtl/nios2_jtag_debug_sysclk_bridge.sv
// System-clock half of the Nios II JTAG debug link.
// Synchronises the virtual-JTAG update strobes, queues {ir_in, sr} snapshots
// in a small command FIFO and hands them to the OCI logic over a valid/ready
// bus, followed by a one-hot take_action / take_no_action pulse.
// Optional feature macro: NIOS2_JTAG_BRIDGE_CMD_COUNT_EN adds the
// cmd_count / drop_count statistics outputs.
`timescale 1ns/1ps

module nios2_jtag_debug_sysclk_bridge #(
    parameter int IR_W        = 2,
    parameter int DR_W        = 38,
    parameter int ACTION_BIT  = 37,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [IR_W-1:0]          ir_in,
    input  logic [DR_W-1:0]          sr,
    input  logic                     vs_udr,
    input  logic                     vs_uir,
    input  logic                     clr_overflow,
    output logic                     ir_update,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
`ifdef NIOS2_JTAG_BRIDGE_CMD_COUNT_EN
    output logic [15:0]              cmd_count,
    output logic [15:0]              drop_count,
`endif
    nios2_jtag_debug_sysclk_bridge_if.master cmd_if
);
    localparam int NUM_CH = 2 ** IR_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int ENT_W  = IR_W + DR_W;

    logic [SYNC_STAGES-1:0] r_udrSync;
    logic [SYNC_STAGES-1:0] r_uirSync;
    logic [SYNC_STAGES-1:0] r_syncFill;
    logic                   r_udrPrev;
    logic                   r_uirPrev;
    logic                   r_udrArm;
    logic                   r_uirArm;
    logic                   r_irUpdate;

    logic [ENT_W-1:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wrPtr;
    logic [PTR_W-1:0]       r_rdPtr;
    logic [LVL_W-1:0]       r_level;
    logic                   r_overflow;

    logic [DR_W-1:0]        r_jdo;
    logic [IR_W-1:0]        r_jdoIr;
    logic [NUM_CH-1:0]      r_takeAction;
    logic [NUM_CH-1:0]      r_takeNoAction;

    logic                   w_udrSync;
    logic                   w_uirSync;
    logic                   w_udrRise;
    logic                   w_uirRise;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_write;
    logic                   w_drop;
    logic [ENT_W-1:0]       w_headEntry;
    logic [IR_W-1:0]        w_headIr;
    logic [DR_W-1:0]        w_headDr;
    logic [NUM_CH-1:0]      w_headOneHot;

    assign w_udrSync = r_udrSync[SYNC_STAGES-1];
    assign w_uirSync = r_uirSync[SYNC_STAGES-1];

    // An edge only counts once the strobe has genuinely been seen low, so a
    // strobe that was already high when reset released cannot fire a command.
    assign w_udrRise = r_udrArm & w_udrSync & ~r_udrPrev;
    assign w_uirRise = r_uirArm & w_uirSync & ~r_uirPrev;

    assign w_full       = (r_level == LVL_W'(DEPTH));
    assign w_pop        = (r_level != '0) && cmd_if.cmd_ready;
    assign w_write      = w_udrRise && (!w_full || w_pop);
    assign w_drop       = w_udrRise && w_full && !w_pop;
    assign w_headEntry  = r_mem[r_rdPtr];
    assign w_headIr     = w_headEntry[ENT_W-1:DR_W];
    assign w_headDr     = w_headEntry[DR_W-1:0];
    assign w_headOneHot = NUM_CH'(1) << w_headIr;

    // Shift both asynchronous strobes through the synchroniser chains; the
    // fill register marks when the chain output holds a real sample rather
    // than its reset value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_udrSync  <= '0;
            r_uirSync  <= '0;
            r_syncFill <= '0;
        end else begin
            r_udrSync  <= {r_udrSync[SYNC_STAGES-2:0], vs_udr};
            r_uirSync  <= {r_uirSync[SYNC_STAGES-2:0], vs_uir};
            r_syncFill <= {r_syncFill[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Edge-detect history, arm flags and the ir_update pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_udrPrev  <= 1'b0;
            r_uirPrev  <= 1'b0;
            r_udrArm   <= 1'b0;
            r_uirArm   <= 1'b0;
            r_irUpdate <= 1'b0;
        end else begin
            r_udrPrev  <= w_udrSync;
            r_uirPrev  <= w_uirSync;
            r_irUpdate <= w_uirRise;
            if (r_syncFill[SYNC_STAGES-1] && !w_udrSync) begin
                r_udrArm <= 1'b1;
            end
            if (r_syncFill[SYNC_STAGES-1] && !w_uirSync) begin
                r_uirArm <= 1'b1;
            end
        end
    end

    // FIFO storage carries no reset; validity is tracked by the level.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wrPtr] <= {ir_in, sr};
        end
    end

    // Pointers and occupancy; a pop on a full FIFO frees room for a
    // same-cycle write, and pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_write) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            r_level <= r_level + LVL_W'(w_write) - LVL_W'(w_pop);
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    // On acceptance, latch the head command and fire its decoded pulse in
    // the following cycle; jdo/jdo_ir hold until the next acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_jdo          <= '0;
            r_jdoIr        <= '0;
            r_takeAction   <= '0;
            r_takeNoAction <= '0;
        end else begin
            r_takeAction   <= '0;
            r_takeNoAction <= '0;
            if (w_pop) begin
                r_jdo   <= w_headDr;
                r_jdoIr <= w_headIr;
                if (w_headDr[ACTION_BIT]) begin
                    r_takeAction <= w_headOneHot;
                end else begin
                    r_takeNoAction <= w_headOneHot;
                end
            end
        end
    end

`ifdef NIOS2_JTAG_BRIDGE_CMD_COUNT_EN
    logic [15:0] r_cmdCount;
    logic [15:0] r_dropCount;

    // Statistics counters; an increment coinciding with a clear loads 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmdCount  <= '0;
            r_dropCount <= '0;
        end else begin
            if (w_pop) begin
                r_cmdCount <= clr_overflow ? 16'd1 : r_cmdCount + 16'd1;
            end else if (clr_overflow) begin
                r_cmdCount <= '0;
            end
            if (w_drop) begin
                r_dropCount <= clr_overflow ? 16'd1 : r_dropCount + 16'd1;
            end else if (clr_overflow) begin
                r_dropCount <= '0;
            end
        end
    end

    assign cmd_count  = r_cmdCount;
    assign drop_count = r_dropCount;
`endif

    assign cmd_if.cmd_valid      = (r_level != '0);
    assign cmd_if.jdo            = r_jdo;
    assign cmd_if.jdo_ir         = r_jdoIr;
    assign cmd_if.take_action    = r_takeAction;
    assign cmd_if.take_no_action = r_takeNoAction;
    assign ir_update             = r_irUpdate;
    assign fifo_level            = r_level;
    assign overflow              = r_overflow;

endmodule

// File: tb/tb_nios2_jtag_debug_sysclk_bridge.sv
// Directed self-checking bench for nios2_jtag_debug_sysclk_bridge with the
// default parameters (IR_W=2, DR_W=38, ACTION_BIT=37, DEPTH=4, SYNC_STAGES=2).
// Builds with or without NIOS2_JTAG_BRIDGE_CMD_COUNT_EN.
`timescale 1ns/1ps

module tb_nios2_jtag_debug_sysclk_bridge;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        vs_udr;
    logic        vs_uir;
    logic        clr_overflow;
    logic        ir_update;
    logic [2:0]  fifo_level;
    logic        overflow;
`ifdef NIOS2_JTAG_BRIDGE_CMD_COUNT_EN
    logic [15:0] cmd_count;
    logic [15:0] drop_count;
`endif

    int checks   = 0;
    int failures = 0;

    nios2_jtag_debug_sysclk_bridge_if #(.IR_W(2), .DR_W(38)) cmdIf ();

    nios2_jtag_debug_sysclk_bridge #(
        .IR_W(2), .DR_W(38), .ACTION_BIT(37), .DEPTH(4), .SYNC_STAGES(2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ir_in        (ir_in),
        .sr           (sr),
        .vs_udr       (vs_udr),
        .vs_uir       (vs_uir),
        .clr_overflow (clr_overflow),
        .ir_update    (ir_update),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
`ifdef NIOS2_JTAG_BRIDGE_CMD_COUNT_EN
        .cmd_count    (cmd_count),
        .drop_count   (drop_count),
`endif
        .cmd_if       (cmdIf.master)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and settle 1 ns past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete udr strobe; the write lands 2 edges after first sampling
    // and the strobe is then held low long enough to re-arm the detector.
    task automatic pulseUdr(input logic [1:0] ir, input logic [37:0] d);
        ir_in  = ir;
        sr     = d;
        vs_udr = 1'b1;
        repeat (3) tick();
        vs_udr = 1'b0;
        repeat (3) tick();
    endtask

    // Power-on reset: every output cleared.
    task automatic test_reset();
        reset_n = 1'b0;
        ir_in = '0; sr = '0; vs_udr = 1'b0; vs_uir = 1'b0;
        clr_overflow = 1'b0; cmdIf.cmd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        checks++;
        if (cmdIf.cmd_valid !== 1'b0 || fifo_level !== 3'd0 || overflow !== 1'b0 || ir_update !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got valid=%b level=%0d ovf=%b iru=%b want 0 0 0 0",
                     cmdIf.cmd_valid, fifo_level, overflow, ir_update);
        end
        checks++;
        if (cmdIf.jdo !== 38'd0 || cmdIf.jdo_ir !== 2'd0 || cmdIf.take_action !== 4'd0 || cmdIf.take_no_action !== 4'd0) begin
            failures++;
            $display("[TB] FAIL reset_bus: got jdo=%h ir=%0d ta=%b tna=%b want all 0",
                     cmdIf.jdo, cmdIf.jdo_ir, cmdIf.take_action, cmdIf.take_no_action);
        end
        repeat (4) tick();
    endtask

    // One action command with cmd_ready already high; checks exact latency.
    task automatic test_single();
        cmdIf.cmd_ready = 1'b1;
        ir_in  = 2'b01;
        sr     = 38'h20_0000_1234;
        vs_udr = 1'b1;
        tick();
        tick();
        checks++;
        if (cmdIf.cmd_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_early_valid: got %b want 0", cmdIf.cmd_valid);
        end
        tick();
        checks++;
        if (cmdIf.cmd_valid !== 1'b1 || cmdIf.take_action !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL single_valid: got valid=%b ta=%b want 1 0000", cmdIf.cmd_valid, cmdIf.take_action);
        end
        tick();
        checks++;
        if (cmdIf.cmd_valid !== 1'b0 || cmdIf.jdo !== 38'h20_0000_1234 || cmdIf.jdo_ir !== 2'd1) begin
            failures++;
            $display("[TB] FAIL single_accept: got valid=%b jdo=%h ir=%0d want 0 2000001234 1",
                     cmdIf.cmd_valid, cmdIf.jdo, cmdIf.jdo_ir);
        end
        checks++;
        if (cmdIf.take_action !== 4'b0010 || cmdIf.take_no_action !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL single_pulse: got ta=%b tna=%b want 0010 0000", cmdIf.take_action, cmdIf.take_no_action);
        end
        vs_udr = 1'b0;
        tick();
        checks++;
        if (cmdIf.take_action !== 4'b0000 || cmdIf.jdo !== 38'h20_0000_1234) begin
            failures++;
            $display("[TB] FAIL single_pulse_end: got ta=%b jdo=%h want 0000 2000001234", cmdIf.take_action, cmdIf.jdo);
        end
        repeat (2) tick();
    endtask

    // Bit 37 clear decodes to take_no_action on channel ir_in.
    task automatic test_no_action();
        ir_in  = 2'd3;
        sr     = 38'h0F_FFFF_FFFF;
        vs_udr = 1'b1;
        repeat (4) tick();
        checks++;
        if (cmdIf.take_no_action !== 4'b1000 || cmdIf.take_action !== 4'b0000 || cmdIf.jdo_ir !== 2'd3) begin
            failures++;
            $display("[TB] FAIL noact_pulse: got tna=%b ta=%b ir=%0d want 1000 0000 3",
                     cmdIf.take_no_action, cmdIf.take_action, cmdIf.jdo_ir);
        end
        vs_udr = 1'b0;
        tick();
        checks++;
        if (cmdIf.take_no_action !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL noact_pulse_end: got tna=%b want 0000", cmdIf.take_no_action);
        end
        repeat (2) tick();
    endtask

    // Five commands into a four-deep FIFO, then drain in order.
    task automatic test_backpressure();
        logic [37:0] data [5];
        for (int k = 0; k < 5; k++) data[k] = 38'h20_0000_0010 + 38'(k);
        cmdIf.cmd_ready = 1'b0;
        for (int k = 0; k < 5; k++) pulseUdr(2'(k), data[k]);
        checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b1 || cmdIf.cmd_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_full: got level=%0d ovf=%b valid=%b want 4 1 1", fifo_level, overflow, cmdIf.cmd_valid);
        end
`ifdef NIOS2_JTAG_BRIDGE_CMD_COUNT_EN
        checks++;
        if (drop_count !== 16'd1) begin
            failures++;
            $display("[TB] FAIL bp_drop_count: got %0d want 1", drop_count);
        end
`endif
        cmdIf.cmd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (cmdIf.jdo !== data[k] || cmdIf.take_action !== (4'd1 << k)) begin
                failures++;
                $display("[TB] FAIL bp_drain%0d: got jdo=%h ta=%b want %h %b",
                         k, cmdIf.jdo, cmdIf.take_action, data[k], 4'd1 << k);
            end
        end
        tick();
        checks++;
        if (cmdIf.take_action !== 4'b0000 || fifo_level !== 3'd0 || cmdIf.jdo !== data[3]) begin
            failures++;
            $display("[TB] FAIL bp_fifth_dropped: got ta=%b level=%0d jdo=%h want 0000 0 %h",
                     cmdIf.take_action, fifo_level, cmdIf.jdo, data[3]);
        end
`ifdef NIOS2_JTAG_BRIDGE_CMD_COUNT_EN
        checks++;
        if (cmd_count !== 16'd6) begin
            failures++;
            $display("[TB] FAIL bp_cmd_count: got %0d want 6", cmd_count);
        end
`endif
        cmdIf.cmd_ready = 1'b0;
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_clear: got ovf=%b want 0", overflow);
        end
`ifdef NIOS2_JTAG_BRIDGE_CMD_COUNT_EN
        checks++;
        if (cmd_count !== 16'd0 || drop_count !== 16'd0) begin
            failures++;
            $display("[TB] FAIL bp_count_clear: got cmd=%0d drop=%0d want 0 0", cmd_count, drop_count);
        end
`endif
    endtask

    // Full FIFO: a write landing on the same edge as a pop is kept.
    task automatic test_full_pop();
        logic [37:0] data [5];
        for (int k = 0; k < 4; k++) data[k] = 38'h20_0000_0100 + 38'(k);
        data[4] = 38'h00_0000_0BEE;
        cmdIf.cmd_ready = 1'b0;
        for (int k = 0; k < 4; k++) pulseUdr(2'(k), data[k]);
        ir_in  = 2'd2;
        sr     = data[4];
        vs_udr = 1'b1;
        tick();
        tick();
        cmdIf.cmd_ready = 1'b1;
        tick();
        vs_udr = 1'b0;
        checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0 || cmdIf.jdo !== data[0]) begin
            failures++;
            $display("[TB] FAIL fullpop_level: got level=%0d ovf=%b jdo=%h want 4 0 %h",
                     fifo_level, overflow, cmdIf.jdo, data[0]);
        end
        for (int k = 1; k < 4; k++) begin
            tick();
            checks++;
            if (cmdIf.jdo !== data[k] || cmdIf.take_action !== (4'd1 << k)) begin
                failures++;
                $display("[TB] FAIL fullpop_drain%0d: got jdo=%h ta=%b want %h %b",
                         k, cmdIf.jdo, cmdIf.take_action, data[k], 4'd1 << k);
            end
        end
        tick();
        checks++;
        if (cmdIf.jdo !== data[4] || cmdIf.take_no_action !== 4'b0100 || cmdIf.take_action !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL fullpop_last: got jdo=%h tna=%b ta=%b want %h 0100 0000",
                     cmdIf.jdo, cmdIf.take_no_action, cmdIf.take_action, data[4]);
        end
        tick();
        checks++;
        if (fifo_level !== 3'd0 || overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fullpop_empty: got level=%0d ovf=%b want 0 0", fifo_level, overflow);
        end
        cmdIf.cmd_ready = 1'b0;
    endtask

    // vs_udr held high across reset release must not create a command.
    task automatic test_reset_held_high();
        cmdIf.cmd_ready = 1'b0;
        vs_udr = 1'b1;
        tick();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (cmdIf.cmd_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL held_high_cycle%0d: got valid=%b want 0", k, cmdIf.cmd_valid);
            end
        end
        vs_udr = 1'b0;
        repeat (3) tick();
        pulseUdr(2'd1, 38'h20_0000_0ABC);
        repeat (4) tick();
        checks++;
        if (fifo_level !== 3'd1) begin
            failures++;
            $display("[TB] FAIL held_high_rearm: got level=%0d want 1", fifo_level);
        end
        cmdIf.cmd_ready = 1'b1;
        tick();
        cmdIf.cmd_ready = 1'b0;
        checks++;
        if (cmdIf.take_action !== 4'b0010 || cmdIf.jdo !== 38'h20_0000_0ABC) begin
            failures++;
            $display("[TB] FAIL held_high_issue: got ta=%b jdo=%h want 0010 2000000abc", cmdIf.take_action, cmdIf.jdo);
        end
        tick();
    endtask

    // ir_update pulse, then an asynchronous reset with two entries queued.
    task automatic test_ir_update();
        cmdIf.cmd_ready = 1'b0;
        pulseUdr(2'd0, 38'h20_0000_0111);
        vs_uir = 1'b1;
        tick();
        tick();
        checks++;
        if (ir_update !== 1'b0) begin
            failures++;
            $display("[TB] FAIL iru_early: got %b want 0", ir_update);
        end
        tick();
        checks++;
        if (ir_update !== 1'b1 || fifo_level !== 3'd1 || cmdIf.jdo !== 38'h20_0000_0ABC) begin
            failures++;
            $display("[TB] FAIL iru_pulse: got iru=%b level=%0d jdo=%h want 1 1 2000000abc",
                     ir_update, fifo_level, cmdIf.jdo);
        end
        tick();
        vs_uir = 1'b0;
        checks++;
        if (ir_update !== 1'b0) begin
            failures++;
            $display("[TB] FAIL iru_end: got %b want 0", ir_update);
        end
        pulseUdr(2'd2, 38'h20_0000_0222);
        checks++;
        if (fifo_level !== 3'd2) begin
            failures++;
            $display("[TB] FAIL midreset_pre: got level=%0d want 2", fifo_level);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (cmdIf.cmd_valid !== 1'b0 || fifo_level !== 3'd0 || cmdIf.jdo !== 38'd0 || overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset: got valid=%b level=%0d jdo=%h ovf=%b want 0 0 0 0",
                     cmdIf.cmd_valid, fifo_level, cmdIf.jdo, overflow);
        end
        #2;
        reset_n = 1'b1;
        repeat (3) tick();
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_single();
        test_no_action();
        test_backpressure();
        test_full_pop();
        test_reset_held_high();
        test_ir_update();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
